// File: rtl/uart_hex_reporter.sv
// Buffers tagged data words and prints each as "<tag><sep><hex digits>\r\n" through uart_tx.
// A small message FIFO decouples the producer from the serial link; refused offers are counted.
module uart_hex_reporter #(
  parameter int         DATA_W    = 16,
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SEP_CHAR  = 8'h3A,
  parameter bit         UPPERCASE = 1'b1
) (
  input  logic                   CLK100MHZ,
  input  logic                   rst_n,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic [7:0]             msg_tag,
  input  logic [DATA_W-1:0]      msg_data,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic                   idle,
  output logic [$clog2(DEPTH):0] pending,
  output logic [7:0]             drop_cnt
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int NDIG   = DATA_W / 4;
  localparam int NBYTES = NDIG + 4;
  localparam int IW     = $clog2(NBYTES);

  localparam logic [IW-1:0] SEP_IDX  = IW'(1);
  localparam logic [IW-1:0] DIG0_IDX = IW'(2);
  localparam logic [IW-1:0] CR_IDX   = IW'(NDIG + 2);
  localparam logic [IW-1:0] LF_IDX   = IW'(NDIG + 3);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [7:0]        tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [7:0]        drop_cnt_reg;
  logic [1:0]        state_reg;
  logic [IW-1:0]     idx_reg;
  logic [7:0]        tag_reg;
  logic [DATA_W-1:0] data_reg;
  logic              tx_start_reg;
  logic [7:0]        tx_data_reg;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              is_digit;
  logic [7:0]        cur_byte;
  logic [7:0]        hex_lut [16];

  // Nibble-to-ASCII table, resolved entirely at elaboration time.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_hex
      localparam int CODE = (gi < 10) ? (48 + gi) : ((UPPERCASE ? 65 : 97) + gi - 10);
      assign hex_lut[gi] = 8'(CODE);
    end
  endgenerate

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign push  = msg_valid && !full;
  assign pop   = (state_reg == S_IDLE) && !empty;

  assign msg_ready = !full;
  assign pending   = wr_ptr_reg - rd_ptr_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign idle      = empty && (state_reg == S_IDLE);
  assign tx_start  = tx_start_reg;
  assign tx_data   = tx_data_reg;

  always_ff @(posedge CLK100MHZ) begin
    if (push) begin
      tag_mem[wr_ptr_reg[AW-1:0]]  <= msg_tag;
      data_mem[wr_ptr_reg[AW-1:0]] <= msg_data;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (msg_valid && full && (drop_cnt_reg != 8'hFF))
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  // Hex digits come from the top nibble of a left-shifting copy of the payload.
  assign is_digit = (idx_reg >= DIG0_IDX) && (idx_reg < CR_IDX);

  always_comb begin
    cur_byte = hex_lut[data_reg[DATA_W-1 -: 4]];
    if (idx_reg == '0)
      cur_byte = tag_reg;
    else if (idx_reg == SEP_IDX)
      cur_byte = SEP_CHAR;
    else if (idx_reg == CR_IDX)
      cur_byte = 8'h0D;
    else if (idx_reg == LF_IDX)
      cur_byte = 8'h0A;
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      tag_reg      <= '0;
      data_reg     <= '0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      tx_start_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (!empty) begin
            tag_reg   <= tag_mem[rd_ptr_reg[AW-1:0]];
            data_reg  <= data_mem[rd_ptr_reg[AW-1:0]];
            idx_reg   <= '0;
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Hold off while the transmitter is still occupied.
          if (!tx_busy) begin
            tx_start_reg <= 1'b1;
            tx_data_reg  <= cur_byte;
            if (is_digit) data_reg <= data_reg << 4;
            state_reg    <= S_ACK;
          end
        end
        S_ACK: begin
          if (tx_busy) state_reg <= S_DONE;
        end
        S_DONE: begin
          if (!tx_busy) begin
            if (idx_reg == LF_IDX) begin
              state_reg <= S_IDLE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= S_ISSUE;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Self-checking bench: three reporter variants, each with a behavioural uart_tx busy model.
module tb_uart_hex_reporter;

  // Shortened stand-in for the 868x10-clock byte time of the real uart_tx.
  localparam int BUSY_CYC = 10;
  localparam int NI       = 3;
  localparam int NV       = 9;

  logic CLK100MHZ = 1'b0;
  logic rst_n     = 1'b1;
  always #5 CLK100MHZ = ~CLK100MHZ;

  logic        msg_valid_a [NI];
  logic        msg_ready_a [NI];
  logic [7:0]  msg_tag_a   [NI];
  logic        tx_start_a  [NI];
  logic [7:0]  tx_data_a   [NI];
  logic        tx_busy_a   [NI];
  logic        idle_a      [NI];
  logic [2:0]  pending_a   [NI];
  logic [7:0]  drop_a      [NI];
  logic        force_busy  [NI];
  logic [15:0] data_up;
  logic [15:0] data_lo;
  logic [31:0] data_wide;

  int busy_cnt [NI];
  int prot_err;
  logic [7:0] cap0 [$];
  logic [7:0] cap1 [$];
  logic [7:0] cap2 [$];

  int n_tests;
  int n_fail;

  uart_hex_reporter #(.DATA_W(16), .DEPTH(4), .SEP_CHAR(8'h3A), .UPPERCASE(1'b1)) u_dut (
    .CLK100MHZ(CLK100MHZ), .rst_n(rst_n),
    .msg_valid(msg_valid_a[0]), .msg_ready(msg_ready_a[0]), .msg_tag(msg_tag_a[0]), .msg_data(data_up),
    .tx_start(tx_start_a[0]), .tx_data(tx_data_a[0]), .tx_busy(tx_busy_a[0]),
    .idle(idle_a[0]), .pending(pending_a[0]), .drop_cnt(drop_a[0])
  );

  uart_hex_reporter #(.DATA_W(16), .DEPTH(4), .SEP_CHAR(8'h3A), .UPPERCASE(1'b0)) u_low (
    .CLK100MHZ(CLK100MHZ), .rst_n(rst_n),
    .msg_valid(msg_valid_a[1]), .msg_ready(msg_ready_a[1]), .msg_tag(msg_tag_a[1]), .msg_data(data_lo),
    .tx_start(tx_start_a[1]), .tx_data(tx_data_a[1]), .tx_busy(tx_busy_a[1]),
    .idle(idle_a[1]), .pending(pending_a[1]), .drop_cnt(drop_a[1])
  );

  uart_hex_reporter #(.DATA_W(32), .DEPTH(4), .SEP_CHAR(8'h3A), .UPPERCASE(1'b1)) u_wide (
    .CLK100MHZ(CLK100MHZ), .rst_n(rst_n),
    .msg_valid(msg_valid_a[2]), .msg_ready(msg_ready_a[2]), .msg_tag(msg_tag_a[2]), .msg_data(data_wide),
    .tx_start(tx_start_a[2]), .tx_data(tx_data_a[2]), .tx_busy(tx_busy_a[2]),
    .idle(idle_a[2]), .pending(pending_a[2]), .drop_cnt(drop_a[2])
  );

  always_comb begin
    for (int i = 0; i < NI; i++) tx_busy_a[i] = force_busy[i] | (busy_cnt[i] != 0);
  end

  // uart_tx model: latch the byte on a start pulse and stay busy for BUSY_CYC clocks.
  always @(posedge CLK100MHZ) begin
    for (int i = 0; i < NI; i++) begin
      if (tx_start_a[i] && !tx_busy_a[i]) busy_cnt[i] <= BUSY_CYC;
      else if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
      if (tx_start_a[i]) begin
        if (tx_busy_a[i]) prot_err <= prot_err + 1;
        if (i == 0) cap0.push_back(tx_data_a[i]);
        else if (i == 1) cap1.push_back(tx_data_a[i]);
        else cap2.push_back(tx_data_a[i]);
      end
    end
  end

  typedef struct {
    int          inst;
    logic [7:0]  tag;
    logic [31:0] data;
    int          len;
    logic [95:0] exp;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0:       return cap0.size();
      1:       return cap1.size();
      default: return cap2.size();
    endcase
  endfunction

  function automatic logic [7:0] qbyte(input int inst, input int idx);
    if (idx >= qsize(inst)) return 8'hXX;
    case (inst)
      0:       return cap0[idx];
      1:       return cap1[idx];
      default: return cap2[idx];
    endcase
  endfunction

  task automatic wait_bytes(input int inst, input int n, input string nm);
    int cyc = 0;
    while (qsize(inst) < n && cyc < 3000) begin
      @(posedge CLK100MHZ);
      #2;
      cyc++;
    end
    check({nm, " bytes arrived"}, 64'(qsize(inst) >= n), 64'd1);
  endtask

  task automatic wait_idle(input int inst, input string nm);
    int cyc = 0;
    while (!idle_a[inst] && cyc < 3000) begin
      @(negedge CLK100MHZ);
      cyc++;
    end
    check({nm, " idle"}, 64'(idle_a[inst]), 64'd1);
  endtask

  task automatic send(input int inst, input logic [7:0] tag, input logic [31:0] data);
    @(negedge CLK100MHZ);
    msg_valid_a[inst] = 1'b1;
    msg_tag_a[inst]   = tag;
    case (inst)
      0:       data_up   = data[15:0];
      1:       data_lo   = data[15:0];
      default: data_wide = data;
    endcase
    @(negedge CLK100MHZ);
    msg_valid_a[inst] = 1'b0;
  endtask

  task automatic check_line(input int inst, input int base, input int len,
                            input logic [95:0] exp, input string nm);
    int f0 = n_fail;
    for (int j = 0; j < len; j++)
      check($sformatf("%s byte%0d", nm, j), 64'(qbyte(inst, base + j)), 64'(exp[8*(len-1-j) +: 8]));
    $display("[TB] %s: inst %0d, %0d bytes checked, %0d bad", nm, inst, len, n_fail - f0);
  endtask

  initial begin
    int base;
    int cyc;
    logic [95:0] exp;

    n_tests = 0;
    n_fail  = 0;
    data_up = '0;
    data_lo = '0;
    data_wide = '0;
    for (int i = 0; i < NI; i++) begin
      msg_valid_a[i] = 1'b0;
      msg_tag_a[i]   = 8'h00;
      force_busy[i]  = 1'b0;
    end

    vecs[0] = '{0, 8'h57, 32'h0000A5A5,  8, 96'h57_3A_41_35_41_35_0D_0A};
    vecs[1] = '{0, 8'h52, 32'h00000000,  8, 96'h52_3A_30_30_30_30_0D_0A};
    vecs[2] = '{0, 8'h57, 32'h0000FFFF,  8, 96'h57_3A_46_46_46_46_0D_0A};
    vecs[3] = '{0, 8'h52, 32'h00001234,  8, 96'h52_3A_31_32_33_34_0D_0A};
    vecs[4] = '{0, 8'h58, 32'h00009AF0,  8, 96'h58_3A_39_41_46_30_0D_0A};
    vecs[5] = '{1, 8'h52, 32'h0000ABCD,  8, 96'h52_3A_61_62_63_64_0D_0A};
    vecs[6] = '{1, 8'h57, 32'h0000F09E,  8, 96'h57_3A_66_30_39_65_0D_0A};
    vecs[7] = '{2, 8'h52, 32'hDEADBEEF, 12, 96'h52_3A_44_45_41_44_42_45_45_46_0D_0A};
    vecs[8] = '{2, 8'h57, 32'h01234567, 12, 96'h57_3A_30_31_32_33_34_35_36_37_0D_0A};

    // Reset state, sampled while reset is held.
    #2 rst_n = 1'b0;
    #1;
    check("rst msg_ready", 64'(msg_ready_a[0]), 64'd1);
    check("rst tx_start",  64'(tx_start_a[0]),  64'd0);
    check("rst tx_data",   64'(tx_data_a[0]),   64'd0);
    check("rst idle",      64'(idle_a[0]),      64'd1);
    check("rst pending",   64'(pending_a[0]),   64'd0);
    check("rst drop_cnt",  64'(drop_a[0]),      64'd0);
    $display("[TB] reset: state checked, failures so far %0d", n_fail);
    repeat (3) @(negedge CLK100MHZ);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK100MHZ);

    // Latency from an empty, idle reporter: accept on edge N, start pulse after edge N+2.
    base = qsize(0);
    @(negedge CLK100MHZ);
    msg_valid_a[0] = 1'b1;
    msg_tag_a[0]   = 8'h4C;
    data_up        = 16'h0F0F;
    @(posedge CLK100MHZ); #1;
    check("lat N tx_start", 64'(tx_start_a[0]), 64'd0);
    check("lat N pending",  64'(pending_a[0]),  64'd1);
    @(negedge CLK100MHZ);
    msg_valid_a[0] = 1'b0;
    @(posedge CLK100MHZ); #1;
    check("lat N+1 tx_start", 64'(tx_start_a[0]), 64'd0);
    check("lat N+1 pending",  64'(pending_a[0]),  64'd0);
    @(posedge CLK100MHZ); #1;
    check("lat N+2 tx_start", 64'(tx_start_a[0]), 64'd1);
    check("lat N+2 tx_data",  64'(tx_data_a[0]),  64'h4C);
    wait_bytes(0, base + 8, "latency");
    wait_idle(0, "latency");
    check_line(0, base, 8, 96'h4C_3A_30_46_30_46_0D_0A, "latency line");

    // Table-driven lines across the three variants.
    for (int v = 0; v < NV; v++) begin
      base = qsize(vecs[v].inst);
      send(vecs[v].inst, vecs[v].tag, vecs[v].data);
      wait_bytes(vecs[v].inst, base + vecs[v].len, $sformatf("vec%0d", v));
      wait_idle(vecs[v].inst, $sformatf("vec%0d", v));
      check($sformatf("vec%0d length", v), 64'(qsize(vecs[v].inst) - base), 64'(vecs[v].len));
      check($sformatf("vec%0d drop_cnt", v), 64'(drop_a[vecs[v].inst]), 64'd0);
      check_line(vecs[v].inst, base, vecs[v].len, vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Fill the FIFO while the transmitter is stuck busy: 1 in the emitter, 4 buffered, 1 refused.
    force_busy[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK100MHZ);
      msg_valid_a[0] = 1'b1;
      msg_tag_a[0]   = 8'(8'h41 + k);
      data_up        = 16'(16'h1111 * k);
    end
    @(negedge CLK100MHZ);
    check("full pending",   64'(pending_a[0]),   64'd4);
    check("full msg_ready", 64'(msg_ready_a[0]), 64'd0);
    check("full drop_cnt",  64'(drop_a[0]),      64'd1);
    $display("[TB] fill: pending %0d, ready %0d, drop %0d", pending_a[0], msg_ready_a[0], drop_a[0]);

    // Keep offering against the full FIFO; the drop counter must stop at 255.
    repeat (300) @(negedge CLK100MHZ);
    msg_valid_a[0] = 1'b0;
    check("sat drop_cnt", 64'(drop_a[0]),    64'd255);
    check("sat pending",  64'(pending_a[0]), 64'd4);
    $display("[TB] saturate: drop %0d, pending %0d", drop_a[0], pending_a[0]);

    base = qsize(0);
    force_busy[0] = 1'b0;
    wait_bytes(0, base + 40, "drain");
    wait_idle(0, "drain");
    check("drain length", 64'(qsize(0) - base), 64'd40);
    for (int k = 0; k < 5; k++) begin
      exp = {32'h0, 8'(8'h41 + k), 8'h3A, {4{8'(8'h30 + k)}}, 8'h0D, 8'h0A};
      check_line(0, base + 8*k, 8, exp, $sformatf("drain line%0d", k));
    end
    check("drain pending", 64'(pending_a[0]), 64'd0);

    // Reset in the middle of the third hex digit, with another message queued behind it.
    base = qsize(0);
    send(0, 8'h57, 32'h1234);
    send(0, 8'h51, 32'h5678);
    wait_bytes(0, base + 4, "pre-reset");
    cyc = 0;
    while (!tx_start_a[0] && cyc < 200) begin
      @(negedge CLK100MHZ);
      cyc++;
    end
    check("pre-reset tx_start", 64'(tx_start_a[0]), 64'd1);
    check("pre-reset tx_data",  64'(tx_data_a[0]),  64'h33);
    check("pre-reset pending",  64'(pending_a[0]),  64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst tx_start",  64'(tx_start_a[0]),  64'd0);
    check("midrst pending",   64'(pending_a[0]),   64'd0);
    check("midrst drop_cnt",  64'(drop_a[0]),      64'd0);
    check("midrst idle",      64'(idle_a[0]),      64'd1);
    check("midrst msg_ready", 64'(msg_ready_a[0]), 64'd1);
    $display("[TB] mid-line reset: tx_start %0d, pending %0d, drop %0d", tx_start_a[0], pending_a[0], drop_a[0]);
    @(negedge CLK100MHZ);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK100MHZ);

    base = qsize(0);
    send(0, 8'h52, 32'h00FF);
    wait_bytes(0, base + 8, "post-reset");
    wait_idle(0, "post-reset");
    check("post-reset length", 64'(qsize(0) - base), 64'd8);
    check_line(0, base, 8, 96'h52_3A_30_30_46_46_0D_0A, "post-reset line");

    check("no start while busy", 64'(prot_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
